// File: rtl/r22sdf_frame_ctrl_if.sv
// rtl/r22sdf_frame_ctrl_if.sv - handshake and status bundle for the FFT frame sequencer
interface r22sdf_frame_ctrl_if #(
    parameter int IDX_W = 10
);
    logic             pipe_rdy;
    logic             s_valid;
    logic             s_sop;
    logic             s_ready;
    logic             flush_req;
    logic             fft_en;
    logic             din_zero;
    logic             m_valid;
    logic             m_sop;
    logic             m_eop;
    logic [IDX_W-1:0] m_index;
    logic             err_sop;
    logic             busy;

    modport master (
        output pipe_rdy, s_valid, s_sop, flush_req,
        input  s_ready, fft_en, din_zero, m_valid, m_sop, m_eop, m_index, err_sop, busy
    );

    modport slave (
        input  pipe_rdy, s_valid, s_sop, flush_req,
        output s_ready, fft_en, din_zero, m_valid, m_sop, m_eop, m_index, err_sop, busy
    );
endinterface

// File: rtl/r22sdf_frame_ctrl.sv
// rtl/r22sdf_frame_ctrl.sv - frame sequencer and output marker for the R2^2SDF FFT pipeline
module r22sdf_frame_ctrl #(
    parameter int FFT_LENGTH = 1024,
    parameter int IDX_W      = 10,
    parameter int PIPE_LAT   = 1023,
    parameter int LAT_W      = 11
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    r22sdf_frame_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_SOP,
        ST_RUN,
        ST_PAD,
        ST_FLUSH
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BIN   = IDX_W'(FFT_LENGTH - 1);
    localparam logic [LAT_W-1:0] LAT_FULL   = LAT_W'(PIPE_LAT);
    localparam logic [LAT_W-1:0] FLUSH_LAST = LAT_W'(PIPE_LAT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   in_cnt_q, in_cnt_d;
    logic [IDX_W-1:0]   out_cnt_q, out_cnt_d;
    logic [LAT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [LAT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               err_sop_q, err_sop_d;

    logic               s_ready;
    logic               accept;
    logic               fft_en;
    logic               din_zero;
    logic               drain_done;
    logic               m_valid;
    logic [IDX_W-1:0]   m_index;

    // Input is only taken while waiting for or running a frame, and never during a stall.
    assign s_ready = bus.pipe_rdy && (state_q == ST_WAIT_SOP || state_q == ST_RUN);
    assign accept  = bus.s_valid && s_ready;

    // Frame sequencing: sop alignment, zero-pad of a partial frame, then a full-latency drain.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fft_en      = 1'b0;
        din_zero    = 1'b0;
        err_sop_d   = 1'b0;
        drain_done  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (bus.pipe_rdy) state_d = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                if (accept) begin
                    if (bus.s_sop) begin
                        fft_en   = 1'b1;
                        in_cnt_d = IDX_W'(1);
                        state_d  = ST_RUN;
                    end else begin
                        err_sop_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                fft_en = accept;
                if (accept) begin
                    in_cnt_d  = in_cnt_q + IDX_W'(1);
                    // Alignment is by count; a misplaced sop is kept as data but reported.
                    err_sop_d = bus.s_sop && (in_cnt_q != '0);
                end else if (bus.pipe_rdy && bus.flush_req) begin
                    state_d = (in_cnt_q == '0) ? ST_FLUSH : ST_PAD;
                end
            end
            ST_PAD: begin
                din_zero = 1'b1;
                fft_en   = bus.pipe_rdy;
                if (bus.pipe_rdy) begin
                    in_cnt_d = in_cnt_q + IDX_W'(1);
                    if (in_cnt_q == LAST_BIN) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                din_zero = 1'b1;
                fft_en   = bus.pipe_rdy;
                if (bus.pipe_rdy) begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        drain_done  = 1'b1;
                        flush_cnt_d = '0;
                        state_d     = ST_WAIT_SOP;
                    end else begin
                        flush_cnt_d = flush_cnt_q + LAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Fill tracking and output bin counting; a completed drain restarts both from empty.
    always_comb begin
        m_valid    = fft_en && (fill_cnt_q == LAT_FULL);
        fill_cnt_d = fill_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (drain_done) begin
            fill_cnt_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (fft_en && (fill_cnt_q < LAT_FULL)) fill_cnt_d = fill_cnt_q + LAT_W'(1);
            if (m_valid) out_cnt_d = out_cnt_q + IDX_W'(1);
        end
    end

    // The pipeline emits bins in bit-reversed order, so the natural index is the reversed count.
    always_comb begin
        m_index = '0;
        for (int i = 0; i < IDX_W; i++) begin
            m_index[i] = out_cnt_q[IDX_W-1-i];
        end
    end

    // State and counter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_INIT;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            fill_cnt_q  <= '0;
            flush_cnt_q <= '0;
            err_sop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_sop_q   <= err_sop_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.fft_en   = fft_en;
    assign bus.din_zero = din_zero;
    assign bus.m_valid  = m_valid;
    assign bus.m_sop    = m_valid && (out_cnt_q == '0);
    assign bus.m_eop    = m_valid && (out_cnt_q == LAST_BIN);
    assign bus.m_index  = m_index;
    assign bus.err_sop  = err_sop_q;
    assign bus.busy     = (state_q != ST_WAIT_SOP);
endmodule

// File: doc/r22sdf_frame_ctrl.md
Name: r22sdf_frame_ctrl

Overview:
- Frame sequencer for the 5-stage R2²SDF FFT pipeline (1024-point by default).
- Accepts a valid/ready sample stream with start-of-frame markers.
- Generates the pipeline advance enable (the pipeline's `sys_en`) and gates it with the aggregated CORDIC-ready status.
- Tracks pipeline fill latency and produces output valid, sop/eop and bit-reversed bin index. Zero-pad flushes the pipeline on request.
- Control only: the sample data path bypasses this block, except for a zero-insert select.

Parameters:
- `FFT_LENGTH`, 1024, points per frame; power of 4.
- `IDX_W`, 10, log2(`FFT_LENGTH`).
- `PIPE_LAT`, 1023, enabled-cycle latency of the pipeline, from a sample into `din` to its result at `dout`.
- `LAT_W`, 11, counter width; 2^`LAT_W` > `PIPE_LAT`.

Ports:
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  synchronous reset, active-high
- `pipe_rdy`  in  1  all stage CORDICs ready (AND of stage ready bits)
- `s_valid`  in  1  input sample valid
- `s_sop`  in  1  input sample is bin 0 of a frame
- `s_ready`  out  1  input sample accepted when `s_valid & s_ready`
- `flush_req`  in  1  level; request zero-pad and drain after the current frame
- `fft_en`  out  1  pipeline advance enable; drives the pipeline `sys_en`
- `din_zero`  out  1  wrapper forces pipeline `din_r`/`din_i` to 0 this cycle
- `m_valid`  out  1  pipeline `dout` holds a valid bin this cycle
- `m_sop`  out  1  first output bin of a frame
- `m_eop`  out  1  last output bin of a frame
- `m_index`  out  `IDX_W`  natural-order bin number of the current output
- `err_sop`  out  1  one-cycle pulse, sop protocol error
- `busy`  out  1  state is not `WAIT_SOP`

Behaviour:
- States: `INIT`, `WAIT_SOP`, `RUN`, `PAD`, `FLUSH`.
- Registers: `in_cnt` (`IDX_W`), `fill_cnt` (`LAT_W`, saturating at `PIPE_LAT`), `out_cnt` (`IDX_W`), `flush_cnt` (`LAT_W`).
- Reset: state=`INIT`; all counters 0. Outputs `s_ready`, `fft_en`, `din_zero`, `m_valid`, `m_sop`, `m_eop`, `err_sop` = 0; `m_index`=0; `busy`=1.
- Combinational outputs (no added latency): `s_ready`, `fft_en`, `din_zero`, `m_valid`, `m_sop`, `m_eop`, `m_index`. `err_sop` is registered and pulses the cycle after the offending beat.
- Stall: `pipe_rdy`=0 forces `s_ready`=0 and `fft_en`=0 in every state. All counters and state hold; `PAD`/`FLUSH` progress freezes.
- `INIT`: waits for `pipe_rdy`=1, then goes to `WAIT_SOP` on the next cycle.
- `WAIT_SOP`:
  - `s_ready`=`pipe_rdy`.
  - Accepted beat with `s_sop`=1: `fft_en`=1, `in_cnt`←1, go to `RUN`.
  - Accepted beat with `s_sop`=0: discarded (`fft_en`=0), `err_sop` pulses.
  - `FFT_LENGTH`=1 is not supported.
- `RUN`:
  - `s_ready`=`pipe_rdy`; `fft_en`=accept.
  - `in_cnt` increments on accept and wraps `FFT_LENGTH`-1→0.
  - `s_sop`=1 on an accepted beat with `in_cnt`≠0: sample is kept as the next bin of the current frame, `err_sop` pulses.
  - `s_sop`=0 when `in_cnt`=0: accepted; frame alignment is by count only.
- Flush entry, evaluated each cycle in `RUN` when no beat is accepted:
  - If `flush_req`=1 and `in_cnt`=0: go to `FLUSH`.
  - If `flush_req`=1 and `in_cnt`≠0: go to `PAD`.
  - If `flush_req` and an accepted beat coincide: the beat wins; flush is evaluated the next cycle.
- `PAD`: `s_ready`=0, `din_zero`=1, `fft_en`=`pipe_rdy`. `in_cnt` advances per enabled cycle; on wrap to 0, go to `FLUSH`.
- `FLUSH`:
  - `s_ready`=0, `din_zero`=1, `fft_en`=`pipe_rdy`; `flush_cnt` increments per enabled cycle.
  - When `flush_cnt` reaches `PIPE_LAT`-1 on an enabled cycle: go to `WAIT_SOP`, clear `flush_cnt`, `fill_cnt` and `out_cnt`.
  - The in-flight frame drains fully; output marking continues during `FLUSH`.
- `fill_cnt` increments on each `fft_en` cycle with `fill_cnt`<`PIPE_LAT`.
- Output marking:
  - `m_valid` = `fft_en` & (`fill_cnt`=`PIPE_LAT`).
  - `out_cnt` increments on `m_valid` and wraps at `FFT_LENGTH`.
  - `m_sop` = `m_valid` & `out_cnt`=0; `m_eop` = `m_valid` & `out_cnt`=`FFT_LENGTH`-1.
  - `m_index` = bit-reverse of `out_cnt` over `IDX_W` bits (the pipeline emits bit-reversed order).
- Reset mid-frame or mid-flush: immediate return to `INIT`. Pipeline contents are not cleared by this block; the first frame after reset re-counts fill from 0.

Test Plan (sim with `FFT_LENGTH`=16, `IDX_W`=4, `PIPE_LAT`=15, `LAT_W`=5):
- Reset held 3 cycles, `pipe_rdy`=1, then 2 back-to-back frames, `s_valid`=1 continuously → `fft_en` high 32 cycles. First `m_valid` on enabled cycle 16, with `m_sop`=1 and `m_index`=0. `m_index` sequence 0,8,4,12,2,…,15; `m_eop` on the 16th valid.
- `s_valid` toggling 1/0 and `pipe_rdy` low 5 cycles mid-frame → `fft_en` only on accepted beats; no `m_valid`/`s_ready` while `pipe_rdy`=0; counters resume unchanged.
- Non-sop beats in `WAIT_SOP`, then an sop → 3 `err_sop` pulses for 3 stray beats; no `fft_en` before the sop beat.
- `flush_req`=1 after 6 samples of a frame → `PAD` 10 cycles with `din_zero`=1, then `FLUSH` 15 cycles; 16 `m_valid` outputs with `m_sop`…`m_eop` then `busy`=0.
- Extra `s_sop` at `in_cnt`=5 → `err_sop` one pulse; frame still closes after 16 total beats.
- `sys_rst` asserted in `FLUSH` → next cycle all outputs at reset values and state `INIT`; the next frame's first `m_valid` again arrives after 15 enabled cycles.
